// File: rtl/wave_fifo_reader_pkg.sv
// Shared types and default sizing for the waveform FIFO reader.
package wave_fifo_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wfr_state_e;

    localparam int unsigned WFR_DATA_W   = 10;
    localparam int unsigned WFR_LINE_LEN = 640;

endpackage

// File: rtl/wave_fifo_reader_if.sv
// FIFO read-side and output stream signals of the waveform reader.
interface wave_fifo_reader_if
    import wave_fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W = WFR_DATA_W
);

    logic              fifo_re;
    logic [DATA_W-1:0] fifo_do;
    logic              fifo_empty;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output fifo_re,
        input  fifo_do,
        input  fifo_empty,
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  fifo_re,
        output fifo_do,
        output fifo_empty,
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/wave_skid_buf2.sv
// Two-entry FIFO-ordered skid buffer; ent0 always holds the oldest sample.
module wave_skid_buf2
    import wave_fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W = WFR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= '0;
            ent0 <= '0;
            ent1 <= '0;
        end else if (clr) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) ent0 <= push_data;
                    else             ent1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new sample lands behind the survivor.
                    if (occ == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = ent0;

endmodule

// File: rtl/wave_fifo_reader.sv
// Reads samples from an unregistered FIFO into a 2-deep skid buffer and streams
// them out with line framing and a saturating underrun counter.
module wave_fifo_reader
    import wave_fifo_reader_pkg::*;
#(
    parameter int unsigned DATA_W   = WFR_DATA_W,
    parameter int unsigned LINE_LEN = WFR_LINE_LEN,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 flush,
    wave_fifo_reader_if.master   bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     underrun_cnt
);

    localparam int unsigned       SC_W     = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [SC_W-1:0]   LAST_IDX = SC_W'(LINE_LEN - 1);

    wfr_state_e      state;
    logic            inflight;
    logic [1:0]      occ;
    logic            pop;
    logic [2:0]      pending;
    logic [SC_W-1:0] samp_cnt;

    assign pop     = bus.out_valid && bus.out_ready;
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // rst also masks the strobe so no FIFO entry is consumed during reset.
    assign bus.fifo_re = !rst && !flush && (state == ST_RUN)
                         && !bus.fifo_empty && (pending < 3'd2);

    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_last  = bus.out_valid && (samp_cnt == LAST_IDX);
    assign busy          = (state != ST_IDLE);

    wave_skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (inflight),
        .push_data (bus.fifo_do),
        .pop       (pop),
        .occ       (occ),
        .head      (bus.out_data)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (enable) state <= ST_RUN;
                ST_RUN:   if (!enable) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (enable)                       state <= ST_RUN;
                    else if (occ == 2'd0 && !inflight) state <= ST_IDLE;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) inflight <= 1'b0;
        else              inflight <= bus.fifo_re;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            samp_cnt <= '0;
        end else if (pop) begin
            if (samp_cnt == LAST_IDX) samp_cnt <= '0;
            else                      samp_cnt <= samp_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if ((state == ST_RUN) && (samp_cnt != '0) && bus.out_ready
                     && !bus.out_valid && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wave_fifo_reader.sv
// Directed bench for wave_fifo_reader with a behavioural unregistered FIFO and sink.
module tb_wave_fifo_reader;

    localparam int unsigned DW = 10;
    localparam int unsigned LL = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic          busy;
    logic [CW-1:0] underrun_cnt;

    int checks = 0;
    int errors = 0;

    wave_fifo_reader_if #(.DATA_W(DW)) bus ();

    wave_fifo_reader #(
        .DATA_W   (DW),
        .LINE_LEN (LL),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .flush        (flush),
        .bus          (bus),
        .busy         (busy),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: read data appears one cycle after the strobe.
    logic [DW-1:0] mem [0:2047];
    int   wr = 0;
    int   rd = 0;
    logic fifo_clr = 1'b0;

    assign bus.fifo_empty = (rd == wr);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd <= wr;
        end else if (bus.fifo_re) begin
            bus.fifo_do <= mem[rd];
            rd          <= rd + 1;
        end
    end

    // Sink and protocol monitor, sampled mid-cycle.
    int            cyc = 0;
    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    int            got_c [$];
    int            ot = 0;
    int            viol_empty = 0;
    int            viol_occ = 0;
    int            viol_stab = 0;
    logic          hold_q = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;
    logic          mon_pop;

    assign mon_pop = bus.out_valid && bus.out_ready;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_pop && !rst) begin
            got_d.push_back(bus.out_data);
            got_l.push_back(bus.out_last);
            got_c.push_back(cyc);
        end
        if (bus.fifo_re && bus.fifo_empty) viol_empty <= viol_empty + 1;
        if ((bus.fifo_re && (ot - int'(mon_pop)) >= 2) || ot > 2) viol_occ <= viol_occ + 1;
        if (hold_q && (bus.out_data !== hold_d || bus.out_last !== hold_l)) viol_stab <= viol_stab + 1;
        ot     <= (rst || flush) ? 0 : ot + int'(bus.fifo_re) - int'(mon_pop);
        hold_q <= bus.out_valid && !bus.out_ready && !rst && !flush;
        hold_d <= bus.out_data;
        hold_l <= bus.out_last;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            mem[wr] = DW'(base + i);
            wr = wr + 1;
        end
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (got_d.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; enable = 1'b0; flush = 1'b0; bus.out_ready = 1'b0; fifo_clr = 1'b1;
        step(2);
        fifo_clr = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        load(2, 50);
        rst = 1'b1; enable = 1'b1; flush = 1'b1; bus.out_ready = 1'b1;
        step(3);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b exp 0", bus.out_last); end
        checks++; if (bus.fifo_re !== 1'b0) begin errors++; $display("FAIL reset_re got %0b exp 0", bus.fifo_re); end
        checks++; if (underrun_cnt !== '0) begin errors++; $display("FAIL reset_underrun got %0d exp 0", underrun_cnt); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data got %0d exp 0", bus.out_data); end
        do_reset;
    endtask

    task automatic test_stream;
        int b;
        bit ok;
        do_reset;
        load(10, 0);
        b = got_d.size();
        bus.out_ready = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        checks++; if (bus.fifo_re !== 1'b0) begin errors++; $display("FAIL stream_re_idle got %0b exp 0", bus.fifo_re); end
        @(negedge clk);
        checks++; if (bus.fifo_re !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_cyc1 re/valid got %0b/%0b exp 1/0", bus.fifo_re, bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_cyc2 valid got %0b exp 0", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(0)) begin errors++; $display("FAIL stream_cyc3 valid/data got %0b/%0d exp 1/0", bus.out_valid, bus.out_data); end
        wait_got(b + 10, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stream_count got %0d exp 10", got_d.size() - b); end
        if (ok) begin
            for (int i = 0; i < 10; i++) begin
                checks++; if (got_d[b+i] !== DW'(i)) begin errors++; $display("FAIL stream_data[%0d] got %0d exp %0d", i, got_d[b+i], i); end
            end
            checks++; if (got_c[b+9] - got_c[b] !== 9) begin errors++; $display("FAIL stream_rate span got %0d exp 9", got_c[b+9] - got_c[b]); end
        end
        checks++; if (viol_empty !== 0) begin errors++; $display("FAIL stream_re_when_empty got %0d exp 0", viol_empty); end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back;
        int b;
        int n;
        int bad_d = 0;
        int bad_l = 0;
        do_reset;
        load(1000, 3);
        for (int i = 0; i < 1000; i++) mem[wr - 1000 + i] = DW'(i * 7 + 3);
        b = got_d.size();
        enable = 1'b1;
        for (int k = 0; k < 6000 && got_d.size() < b + 1000; k++) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step(1);
        end
        n = got_d.size() - b;
        checks++; if (n !== 1000) begin errors++; $display("FAIL bp_count got %0d exp 1000", n); end
        for (int i = 0; i < n && i < 1000; i++) begin
            if (got_d[b+i] !== DW'(i * 7 + 3)) bad_d++;
            if (got_l[b+i] !== (i % 4 == 3)) bad_l++;
        end
        checks++; if (bad_d !== 0) begin errors++; $display("FAIL bp_order bad samples got %0d exp 0", bad_d); end
        checks++; if (bad_l !== 0) begin errors++; $display("FAIL bp_last bad flags got %0d exp 0", bad_l); end
        checks++; if (viol_occ !== 0) begin errors++; $display("FAIL bp_occupancy violations got %0d exp 0", viol_occ); end
        checks++; if (viol_stab !== 0) begin errors++; $display("FAIL bp_stable violations got %0d exp 0", viol_stab); end
        checks++; if (viol_empty !== 0) begin errors++; $display("FAIL bp_re_when_empty got %0d exp 0", viol_empty); end
        enable = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_line;
        int b;
        bit ok;
        do_reset;
        load(12, 100);
        b = got_d.size();
        bus.out_ready = 1'b1;
        enable = 1'b1;
        wait_got(b + 12, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL line_count got %0d exp 12", got_d.size() - b); end
        if (ok) begin
            for (int i = 0; i < 12; i++) begin
                checks++; if (got_l[b+i] !== (i % 4 == 3)) begin errors++; $display("FAIL line_last[%0d] got %0b exp %0b", i, got_l[b+i], (i % 4 == 3)); end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_underrun;
        int b;
        bit ok;
        do_reset;
        load(3, 0);
        b = got_d.size();
        bus.out_ready = 1'b1;
        enable = 1'b1;
        wait_got(b + 3, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL underrun_fill got %0d exp 3", got_d.size() - b); end
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (underrun_cnt !== CW'(5)) begin errors++; $display("FAIL underrun_five got %0d exp 5", underrun_cnt); end
        step(2);
        checks++; if (underrun_cnt !== CW'(5)) begin errors++; $display("FAIL underrun_hold_ready0 got %0d exp 5", underrun_cnt); end
        bus.out_ready = 1'b1;
        step(20);
        @(negedge clk);
        checks++; if (underrun_cnt !== CW'(15)) begin errors++; $display("FAIL underrun_sat got %0d exp 15", underrun_cnt); end
        step(3);
        checks++; if (underrun_cnt !== CW'(15)) begin errors++; $display("FAIL underrun_sat_hold got %0d exp 15", underrun_cnt); end
        enable = 1'b0;
    endtask

    task automatic test_drain;
        int b;
        int re_cnt = 0;
        do_reset;
        load(10, 200);
        b = got_d.size();
        bus.out_ready = 1'b0;
        enable = 1'b1;
        step(6);
        @(negedge clk);
        checks++; if (bus.fifo_re !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain_full re/valid got %0b/%0b exp 0/1", bus.fifo_re, bus.out_valid); end
        @(posedge clk);
        #1 enable = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.fifo_re !== 1'b1) begin errors++; $display("FAIL drain_last_read got %0b exp 1", bus.fifo_re); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %0b exp 1", busy); end
        for (int k = 0; k < 8; k++) begin
            if (bus.fifo_re) re_cnt++;
            @(negedge clk);
        end
        checks++; if (re_cnt !== 0) begin errors++; $display("FAIL drain_no_reads got %0d exp 0", re_cnt); end
        checks++; if (got_d.size() - b !== 3) begin errors++; $display("FAIL drain_count got %0d exp 3", got_d.size() - b); end
        if (got_d.size() - b >= 3) begin
            checks++; if (got_d[b] !== DW'(200) || got_d[b+1] !== DW'(201) || got_d[b+2] !== DW'(202)) begin
                errors++; $display("FAIL drain_data got %0d,%0d,%0d exp 200,201,202", got_d[b], got_d[b+1], got_d[b+2]);
            end
        end
        checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_idle busy/valid got %0b/%0b exp 0/0", busy, bus.out_valid); end
    endtask

    task automatic test_flush;
        int b;
        bit ok;
        do_reset;
        load(10, 300);
        b = got_d.size();
        bus.out_ready = 1'b1;
        enable = 1'b1;
        wait_got(b + 2, 40, ok);
        #1 flush = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.fifo_re !== 1'b0) begin errors++; $display("FAIL flush_re got %0b exp 0", bus.fifo_re); end
        @(posedge clk);
        #1 flush = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_after valid/busy got %0b/%0b exp 0/0", bus.out_valid, busy); end
        wait_got(b + 8, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL flush_count got %0d exp 8", got_d.size() - b); end
        if (ok) begin
            checks++; if (got_d[b+2] !== DW'(304)) begin errors++; $display("FAIL flush_first got %0d exp 304", got_d[b+2]); end
            for (int i = 0; i < 6; i++) begin
                checks++; if (got_l[b+2+i] !== (i == 3)) begin errors++; $display("FAIL flush_last[%0d] got %0b exp %0b", i, got_l[b+2+i], (i == 3)); end
            end
        end
        enable = 1'b0;

        do_reset;
        load(10, 400);
        b = got_d.size();
        bus.out_ready = 1'b1;
        enable = 1'b1;
        wait_got(b + 2, 40, ok);
        #1 rst = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
            errors++; $display("FAIL rst_mid busy/valid/last got %0b/%0b/%0b exp 0/0/0", busy, bus.out_valid, bus.out_last);
        end
        checks++; if (bus.fifo_re !== 1'b0 || underrun_cnt !== '0 || bus.out_data !== '0) begin
            errors++; $display("FAIL rst_mid re/underrun/data got %0b/%0d/%0d exp 0/0/0", bus.fifo_re, underrun_cnt, bus.out_data);
        end
        @(posedge clk);
        #1 rst = 1'b0; bus.out_ready = 1'b1;
        wait_got(b + 8, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_count got %0d exp 8", got_d.size() - b); end
        if (ok) begin
            checks++; if (got_d[b+2] !== DW'(404)) begin errors++; $display("FAIL rst_mid_first got %0d exp 404", got_d[b+2]); end
            checks++; if (got_d[b+7] !== DW'(409) || got_l[b+5] !== 1'b1) begin errors++; $display("FAIL rst_mid_tail data/last got %0d/%0b exp 409/1", got_d[b+7], got_l[b+5]); end
        end
        enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
        test_reset;
        test_stream;
        test_back_to_back;
        test_line;
        test_underrun;
        test_drain;
        test_flush;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wave_fifo_reader.md
WAVE_FIFO_READER -- requirements
Module: wave_fifo_reader

Interface
REQ-001 SHALL have parameters: DATA_W, default 10, sample width; LINE_LEN, default 640, samples per display line; CNT_W, default 16, underrun counter width.
REQ-002 SHALL have ports: clk  in  1  single clock; rst  in  1  synchronous reset, active-high.
REQ-003 SHALL have ports: enable  in  1  run request; flush  in  1  discard buffered data, return to IDLE.
REQ-004 SHALL have FIFO read-side ports: fifo_re  out  1  read strobe; fifo_do  in  DATA_W  read data; fifo_empty  in  1  FIFO empty flag.
REQ-005 SHALL have stream ports: out_data  out  DATA_W  sample; out_valid  out  1  sample available; out_ready  in  1  sink accepts; out_last  out  1  last sample of a line.
REQ-006 SHALL have status ports: busy  out  1  state is not IDLE; underrun_cnt  out  CNT_W  saturating underrun count.

Function
REQ-007 SHALL implement states IDLE, RUN and DRAIN.
REQ-008 Transitions SHALL be: IDLE->RUN when enable=1; RUN->DRAIN when enable=0; DRAIN->IDLE when the buffer is empty and no read is in flight; DRAIN->RUN when enable=1.
REQ-009 flush=1 SHALL force IDLE next cycle from any state, clear the buffer and sample counter, and discard data of any read in flight; flush SHALL take priority over enable.
REQ-010 The FIFO SHALL be treated as unregistered: fifo_do is valid exactly one cycle after fifo_re=1.
REQ-011 fifo_re SHALL equal state==RUN && !fifo_empty && !flush && (occ + inflight - pop) < 2; it SHALL never assert while fifo_empty=1.
REQ-012 In REQ-011, occ is buffer occupancy (0..2), inflight is fifo_re registered, and pop is out_valid && out_ready.
REQ-013 SHALL hold a 2-entry FIFO-ordered skid buffer; fifo_do SHALL be written when inflight=1.
REQ-014 out_valid SHALL equal occ!=0; out_data SHALL be the oldest entry.
REQ-015 out_data and out_last SHALL be stable while out_valid && !out_ready.
REQ-016 Simultaneous write and pop SHALL leave occ unchanged; occ SHALL never exceed 2 and no sample SHALL be lost or duplicated.
REQ-017 Steady state with out_ready=1 and the FIFO non-empty SHALL deliver one sample per cycle.
REQ-018 Latency SHALL be: enable high at edge N -> fifo_re in cycle N+1 -> out_valid in cycle N+3.
REQ-019 The sample counter (0..LINE_LEN-1) SHALL increment on each pop and wrap to 0 after LINE_LEN-1.
REQ-020 out_last SHALL equal out_valid && counter==LINE_LEN-1.
REQ-021 underrun_cnt SHALL increment, saturating at all-ones, in each cycle where state==RUN && counter!=0 && out_ready && !out_valid.
REQ-022 DRAIN SHALL issue no reads but SHALL deliver all buffered and in-flight samples.

Reset
REQ-023 rst=1 SHALL set: state IDLE, occ 0, inflight 0, counter 0, underrun_cnt 0, fifo_re 0, out_valid 0, out_last 0, busy 0, out_data 0.
REQ-024 rst SHALL take priority over flush and enable; data of a read in flight at reset SHALL be discarded.

Structure
REQ-025 A shared package SHALL hold the state enum type and the default DATA_W and LINE_LEN constants.
REQ-026 The skid buffer SHALL be a sub-module, wave_skid_buf2, with push/pop/occ ports; all other logic SHALL be in wave_fifo_reader.

Verification
REQ-027 Stream test: FIFO model holding 0..9, enable=1, out_ready=1 -> out_data 0..9 on consecutive cycles, first out_valid 3 cycles after enable, no fifo_re when fifo_empty.
REQ-028 Backpressure test: out_ready toggled with a random pattern over 1000 samples -> in-order, loss-free output, occ<=2, fifo_re low while occ+inflight-pop=2.
REQ-029 Line test: LINE_LEN=4, 12 samples -> out_last on samples 3, 7 and 11 only.
REQ-030 Underrun test: FIFO empties after sample 2 of a line with out_ready=1 for 5 cycles -> underrun_cnt=5; saturation -> held at 2^CNT_W-1.
REQ-031 Drain test: enable dropped with 2 buffered and 1 in flight -> 3 more samples delivered, then IDLE, busy=0.
REQ-032 Flush/reset test: flush with a read in flight -> out_valid 0 next cycle, counter 0, the in-flight sample never appears; repeat with rst -> all REQ-023 values.
